// File: rtl/adc_request_scheduler.sv
// rtl/adc_request_scheduler.sv - round-robin scheduler sharing one serial ADC core among three requesters
//
// Optional feature macro: ADC_SCHED_TIMEOUT_EN
//   defined   : WAIT aborts after TIMEOUT_CYCLES without adc_done and sets sticky timeout_err
//   undefined : WAIT persists until adc_done or reset, timeout_err tied low
//
// Ports:
//   CLOCK_50      in   1   system clock
//   reset         in   1   synchronous active-high reset
//   req           in   3   per-requester conversion request (level)
//   mode_sel      in   3   eligibility mask, requester i eligible while mode_sel[i]=1
//   adc_start     out  1   one-cycle start pulse to the ADC core
//   adc_channel   out  3   channel of the current conversion
//   adc_done      in   1   conversion complete pulse, adc_data valid same cycle
//   adc_data      in   12  conversion result from the core
//   grant         out  3   one-hot owner of the current conversion
//   result        out  12  last captured result
//   result_valid  out  3   one-cycle strobe to the owner of result
//   busy          out  1   high in every state except IDLE
//   timeout_err   out  1   sticky abort flag
module adc_request_scheduler #(
  parameter logic [2:0]  CH0            = 3'd0,
  parameter logic [2:0]  CH1            = 3'd1,
  parameter logic [2:0]  CH2            = 3'd2,
  parameter int unsigned HOLDOFF        = 50,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  mode_sel,
  output logic        adc_start,
  output logic [2:0]  adc_channel,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [2:0]  grant,
  output logic [11:0] result,
  output logic [2:0]  result_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER,
    S_HOLDOFF
  } state_t;

  // One counter serves both the holdoff and the WAIT timeout; it only ever
  // reaches (limit - 1), so $clog2 of the larger limit is enough.
  localparam int unsigned CNT_MAX = (HOLDOFF > TIMEOUT_CYCLES) ? HOLDOFF : TIMEOUT_CYCLES;
  localparam int          CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);

  // With HOLDOFF=0 a finished (or aborted) conversion returns straight to IDLE.
  localparam state_t AFTER_RUN = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    chan_q, chan_d;
  logic          start_q, start_d;
  logic [11:0]   result_q, result_d;
  logic [2:0]    rv_q, rv_d;
  logic          busy_q, busy_d;

  logic [2:0]    eligible;
  logic          sel_found;
  logic [1:0]    sel_idx;
  logic [1:0]    cand;
  logic [2:0]    sel_chan;
  logic          timeout_hit;

  // Round-robin pick: walk last+3, last+2, last+1 (mod 3) so the candidate
  // closest after last overwrites the others.
  always_comb begin
    eligible  = req & mode_sel;
    sel_found = |eligible;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (eligible[cand]) begin
        sel_idx = cand;
      end
    end
    case (sel_idx)
      2'd0:    sel_chan = CH0;
      2'd1:    sel_chan = CH1;
      default: sel_chan = CH2;
    endcase
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  assign timeout_hit = (state_q == S_WAIT) && !adc_done && (cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register plus registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 2'd2;
      grant_q  <= 3'b000;
      chan_q   <= 3'd0;
      start_q  <= 1'b0;
      result_q <= 12'h000;
      rv_q     <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      chan_q   <= chan_d;
      start_q  <= start_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic. The counter is cleared whenever it is not counting so
  // both WAIT and HOLDOFF always start from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          state_d = S_DELIVER;
        end else if (timeout_hit) begin
          state_d = AFTER_RUN;
        end else begin
`ifdef ADC_SCHED_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_DELIVER: begin
        state_d = AFTER_RUN;
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next values; everything leaves the block through a flop.
  always_comb begin
    last_d   = last_q;
    grant_d  = grant_q;
    chan_d   = chan_q;
    start_d  = 1'b0;
    result_d = result_q;
    rv_d     = 3'b000;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = 3'b001 << sel_idx;
          chan_d  = sel_chan;
          start_d = 1'b1;
          last_d  = sel_idx;
        end
      end
      S_WAIT: begin
        if (adc_done) begin
          result_d = adc_data;
          // Strobe is dropped if the owner lost eligibility mid-conversion.
          rv_d     = grant_q & mode_sel;
        end else if (timeout_hit) begin
          grant_d  = 3'b000;
        end
      end
      S_DELIVER: begin
        grant_d = 3'b000;
      end
      default: begin
      end
    endcase
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  logic terr_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset)            terr_q <= 1'b0;
    else if (timeout_hit) terr_q <= 1'b1;
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign adc_start    = start_q;
  assign adc_channel  = chan_q;
  assign grant        = grant_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_request_scheduler.sv
// tb/tb_adc_request_scheduler.sv - self-checking bench for adc_request_scheduler
module tb_adc_request_scheduler;

  localparam int HO = 3;
  localparam int TO = 16;
  localparam logic [2:0] CHS [3] = '{3'd0, 3'd1, 3'd2};

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [2:0]  req      = 3'b000;
  logic [2:0]  mode_sel = 3'b000;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic        adc_start;
  logic [2:0]  adc_channel;
  logic [2:0]  grant;
  logic [11:0] result;
  logic [2:0]  result_valid;
  logic        busy;
  logic        timeout_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  adc_request_scheduler #(
    .HOLDOFF        (HO),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .req          (req),
    .mode_sel     (mode_sel),
    .adc_start    (adc_start),
    .adc_channel  (adc_channel),
    .adc_done     (adc_done),
    .adc_data     (adc_data),
    .grant        (grant),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_m = 2;
  logic [11:0] res_m = 12'h000;

  // Reference rule: first eligible requester searching upward from last+1 with wrap.
  function automatic int pick(input logic [2:0] e, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (((e >> idx) & 3'b001) != 3'b000) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_start(input int limit, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < limit) begin
      if (adc_start === 1'b1) seen = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  task automatic drive_done(input int lat, input logic [11:0] data);
    repeat (lat) tick();
    adc_done = 1'b1;
    adc_data = data;
    tick();
    adc_done = 1'b0;
    adc_data = 12'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = 3'b000; adc_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    last_m = 2; res_m = 12'h000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_cmp++; if (adc_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", adc_start); end
    n_cmp++; if (adc_channel !== 3'd0) begin n_bad++; $display("FAIL reset_channel: got %0d want 0", adc_channel); end
    n_cmp++; if (result !== 12'h000) begin n_bad++; $display("FAIL reset_result: got %h want 000", result); end
    n_cmp++; if (result_valid !== 3'b000) begin n_bad++; $display("FAIL reset_rv: got %b want 000", result_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit seen; int waited;
    req = 3'b001; mode_sel = 3'b001;
    wait_start(10, seen, waited);
    n_cmp++; if (!seen || waited != 1) begin n_bad++; $display("FAIL single_issue_latency: got seen=%0d after %0d want 1", seen, waited); end
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL single_grant: got %b want 001", grant); end
    n_cmp++; if (adc_channel !== CHS[0]) begin n_bad++; $display("FAIL single_channel: got %0d want %0d", adc_channel, CHS[0]); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    last_m = 0;
    tick();
    n_cmp++; if (adc_start !== 1'b0) begin n_bad++; $display("FAIL single_start_width: got %b want 0", adc_start); end
    drive_done(19, 12'hABC);
    res_m = 12'hABC;
    n_cmp++; if (result !== 12'hABC) begin n_bad++; $display("FAIL single_result: got %h want abc", result); end
    n_cmp++; if (result_valid !== 3'b001) begin n_bad++; $display("FAIL single_rv: got %b want 001", result_valid); end
    tick();
    n_cmp++; if (result_valid !== 3'b000) begin n_bad++; $display("FAIL single_rv_width: got %b want 000", result_valid); end
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL single_grant_clear: got %b want 000", grant); end
    wait_start(HO + 20, seen, waited);
    n_cmp++; if (!seen || waited != HO + 1) begin n_bad++; $display("FAIL single_holdoff_gap: got seen=%0d after %0d want %0d", seen, waited, HO + 1); end
    req = 3'b000;
    tick();
    drive_done(5, 12'h123);
    res_m = 12'h123;
    n_cmp++; if (result !== res_m) begin n_bad++; $display("FAIL single_result2: got %h want %h", result, res_m); end
    repeat (HO + 2) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_back_idle: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    bit seen; int waited; int exp; logic [11:0] d;
    apply_reset();
    req = 3'b111; mode_sel = 3'b111;
    for (int i = 0; i < 6; i++) begin
      exp = pick(req & mode_sel, last_m);
      wait_start(HO + 20, seen, waited);
      n_cmp++; if (!seen || grant !== (3'b001 << exp)) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, 3'b001 << exp); end
      n_cmp++; if (adc_channel !== CHS[exp]) begin n_bad++; $display("FAIL rr_channel[%0d]: got %0d want %0d", i, adc_channel, CHS[exp]); end
      last_m = exp;
      d = 12'($urandom);
      tick();
      drive_done($urandom_range(0, 8), d);
      res_m = d;
      if (i == 5) req = 3'b000;
      n_cmp++; if (result !== res_m || result_valid !== (3'b001 << exp)) begin n_bad++; $display("FAIL rr_result[%0d]: got %h/%b want %h/%b", i, result, result_valid, res_m, 3'b001 << exp); end
    end
    repeat (HO + 2) tick();
  endtask

  task automatic test_mode_mask();
    bit seen; int waited; logic [11:0] d;
    req = 3'b111; mode_sel = 3'b010;
    for (int i = 0; i < 3; i++) begin
      wait_start(HO + 20, seen, waited);
      n_cmp++; if (!seen || grant !== 3'b010 || adc_channel !== CHS[1]) begin n_bad++; $display("FAIL mask_grant[%0d]: got %b ch %0d want 010 ch %0d", i, grant, adc_channel, CHS[1]); end
      last_m = 1;
      d = 12'($urandom);
      tick();
      drive_done($urandom_range(0, 6), d);
      res_m = d;
      if (i == 2) req = 3'b000;
      n_cmp++; if (result !== res_m || result_valid !== 3'b010) begin n_bad++; $display("FAIL mask_result[%0d]: got %h/%b want %h/010", i, result, result_valid, res_m); end
    end
    repeat (HO + 2) tick();
  endtask

  task automatic test_random();
    bit seen; int waited; int exp; logic [11:0] d; logic [2:0] exp_rv;
    for (int i = 0; i < 24; i++) begin
      req = 3'($urandom); mode_sel = 3'($urandom);
      exp = pick(req & mode_sel, last_m);
      if (exp < 0) begin
        wait_start(HO + 8, seen, waited);
        n_cmp++; if (seen) begin n_bad++; $display("FAIL rand_no_grant[%0d]: got start with grant %b want none", i, grant); end
      end else begin
        wait_start(2 * HO + 10, seen, waited);
        n_cmp++; if (!seen || grant !== (3'b001 << exp) || adc_channel !== CHS[exp]) begin n_bad++; $display("FAIL rand_grant[%0d]: got %b ch %0d want %b ch %0d", i, grant, adc_channel, 3'b001 << exp, CHS[exp]); end
        last_m = exp;
        tick();
        if ($urandom_range(0, 1) == 1) mode_sel = 3'($urandom);
        if ($urandom_range(0, 1) == 1) req = 3'($urandom);
        exp_rv = (((mode_sel >> exp) & 3'b001) != 3'b000) ? (3'b001 << exp) : 3'b000;
        d = 12'($urandom);
        drive_done($urandom_range(0, 6), d);
        res_m = d;
        n_cmp++; if (result !== res_m || result_valid !== exp_rv) begin n_bad++; $display("FAIL rand_result[%0d]: got %h/%b want %h/%b", i, result, result_valid, res_m, exp_rv); end
      end
    end
    req = 3'b000;
    repeat (HO + 3) tick();
  endtask

  task automatic test_mode_drop();
    bit seen; int waited;
    req = 3'b100; mode_sel = 3'b100;
    wait_start(HO + 20, seen, waited);
    n_cmp++; if (!seen || grant !== 3'b100 || adc_channel !== CHS[2]) begin n_bad++; $display("FAIL drop_grant: got %b ch %0d want 100 ch %0d", grant, adc_channel, CHS[2]); end
    last_m = 2;
    tick();
    mode_sel = 3'b000;
    drive_done(4, 12'h5A5);
    res_m = 12'h5A5;
    n_cmp++; if (result !== 12'h5A5) begin n_bad++; $display("FAIL drop_result: got %h want 5a5", result); end
    n_cmp++; if (result_valid !== 3'b000) begin n_bad++; $display("FAIL drop_rv: got %b want 000", result_valid); end
    repeat (HO + 1) tick();
    n_cmp++; if (busy !== 1'b0 || grant !== 3'b000) begin n_bad++; $display("FAIL drop_idle: got busy %b grant %b want 0/000", busy, grant); end
    req = 3'b000;
  endtask

  task automatic test_reset_mid();
    bit seen; int waited; bit rv_seen;
    req = 3'b011; mode_sel = 3'b011;
    wait_start(HO + 20, seen, waited);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmid_start: got no start want start"); end
    repeat (3) tick();
    reset = 1'b1; req = 3'b000;
    tick();
    reset = 1'b0;
    last_m = 2; res_m = 12'h000;
    n_cmp++; if (grant !== 3'b000 || adc_start !== 1'b0 || adc_channel !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_outputs: got g%b s%b c%0d b%b want 000/0/0/0", grant, adc_start, adc_channel, busy); end
    n_cmp++; if (result !== 12'h000 || result_valid !== 3'b000) begin n_bad++; $display("FAIL rmid_result: got %h/%b want 000/000", result, result_valid); end
    tick();
    adc_done = 1'b1; adc_data = 12'hFED;
    tick();
    adc_done = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (result_valid !== 3'b000) rv_seen = 1'b1;
      tick();
    end
    n_cmp++; if (rv_seen || result !== 12'h000 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_late_done: got rv_seen %0d result %h busy %b want 0/000/0", rv_seen, result, busy); end
    req = 3'b111; mode_sel = 3'b111;
    wait_start(10, seen, waited);
    n_cmp++; if (!seen || grant !== 3'b001) begin n_bad++; $display("FAIL rmid_next_grant: got %b want 001", grant); end
    last_m = 0;
    req = 3'b000;
    tick();
    drive_done(3, 12'h321);
    res_m = 12'h321;
    n_cmp++; if (result !== res_m || result_valid !== 3'b001) begin n_bad++; $display("FAIL rmid_after: got %h/%b want %h/001", result, result_valid, res_m); end
    repeat (HO + 2) tick();
  endtask

`ifdef ADC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit seen; int waited;
    req = 3'b001; mode_sel = 3'b001;
    wait_start(HO + 20, seen, waited);
    n_cmp++; if (!seen || grant !== 3'b001) begin n_bad++; $display("FAIL to_grant: got %b want 001", grant); end
    last_m = 0;
    req = 3'b000;
    repeat (TO) tick();
    n_cmp++; if (grant !== 3'b001 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_early: got grant %b terr %b want 001/0", grant, timeout_err); end
    tick();
    n_cmp++; if (grant !== 3'b000 || timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_abort: got grant %b terr %b want 000/1", grant, timeout_err); end
    n_cmp++; if (result !== res_m || result_valid !== 3'b000) begin n_bad++; $display("FAIL to_result: got %h/%b want %h/000", result, result_valid, res_m); end
    repeat (HO + 4) tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    req = 3'b010; mode_sel = 3'b010;
    wait_start(HO + 20, seen, waited);
    n_cmp++; if (!seen || grant !== 3'b010) begin n_bad++; $display("FAIL to_regrant: got %b want 010", grant); end
    last_m = 1;
    req = 3'b000;
    tick();
    drive_done(2, 12'h777);
    res_m = 12'h777;
    n_cmp++; if (result !== res_m || result_valid !== 3'b010 || timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_after: got %h/%b/%b want %h/010/1", result, result_valid, timeout_err, res_m); end
    repeat (HO + 2) tick();
  endtask
`else
  task automatic test_timeout();
    bit seen; int waited;
    req = 3'b001; mode_sel = 3'b001;
    wait_start(HO + 20, seen, waited);
    last_m = 0;
    req = 3'b000;
    repeat (3 * TO) tick();
    n_cmp++; if (!seen || grant !== 3'b001 || busy !== 1'b1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL nto_wait_holds: got grant %b busy %b terr %b want 001/1/0", grant, busy, timeout_err); end
    drive_done(0, 12'h4C4);
    res_m = 12'h4C4;
    n_cmp++; if (result !== res_m || result_valid !== 3'b001) begin n_bad++; $display("FAIL nto_result: got %h/%b want %h/001", result, result_valid, res_m); end
    repeat (HO + 2) tick();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mode_mask();
    test_random();
    test_mode_drop();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_request_scheduler.md
# adc_request_scheduler

Shares the single serial ADC core between the three application modules (button position, angle, moisture). It accepts per-requester conversion requests gated by the one-hot mode select, arbitrates round-robin, drives the core's start/channel inputs, and returns each 12-bit result to the granted requester with a one-cycle valid strobe. It sits between the top-level mode logic and the ADC interface block, replacing direct switch-driven channel selection.

## Interface

- CH0, 3'd0, ADC channel converted for requester 0
- CH1, 3'd1, ADC channel converted for requester 1
- CH2, 3'd2, ADC channel converted for requester 2
- HOLDOFF, 50, idle cycles after each conversion before the next grant; 0 allowed
- TIMEOUT_CYCLES, 4096, WAIT cycles before abort; only used when the timeout feature is compiled in
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- req  input  3  per-requester conversion request, level
- mode_sel  input  3  eligibility mask (module one/two/three); requester i is eligible only while mode_sel[i]=1
- adc_start  output  1  one-cycle start pulse to ADC core
- adc_channel  output  3  channel for the current conversion, stable from ISSUE through WAIT
- adc_done  input  1  one-cycle pulse from core, adc_data valid in the same cycle
- adc_data  input  12  conversion result
- grant  output  3  one-hot owner of the current conversion, 0 when no conversion is in progress
- result  output  12  last captured result, held until the next capture
- result_valid  output  3  one-cycle strobe to the requester owning result
- busy  output  1  high in every state except IDLE
- timeout_err  output  1  sticky abort flag

## Operation

- FSM states: IDLE, ISSUE, WAIT, DELIVER, HOLDOFF. All outputs are registered.
- IDLE: eligible = req & mode_sel. If nonzero, pick the first set bit searching upward (with wrap) from last+1. Load grant and adc_channel (CHi) and go to ISSUE. last := the selected index.
- ISSUE: adc_start=1 for exactly this cycle. Go to WAIT.
- WAIT: on adc_done, capture adc_data into result and go to DELIVER. adc_done in any other state is ignored.
- DELIVER: result_valid[i]=1 for the granted i only if mode_sel[i] is still 1; otherwise the strobe is suppressed and result is still updated. Clear grant. Go to HOLDOFF, or straight to IDLE when HOLDOFF=0.
- HOLDOFF: count HOLDOFF cycles, then go to IDLE.
- req may drop after grant; the conversion still completes.
- A mode_sel change mid-conversion does not abort the conversion.
- Reset values:
  - state IDLE
  - grant=0, adc_start=0, adc_channel=0
  - result=0, result_valid=0, busy=0, timeout_err=0
  - last=2, so requester 0 has first priority after reset
- Reset asserted mid-conversion forces the reset values on the next edge. A late adc_done is then ignored because the FSM is in IDLE.

## Timing

- req/mode_sel sampled at edge k in IDLE -> grant, adc_channel, adc_start, busy high in cycle k+1.
- WAIT begins at k+2.
- adc_done sampled at edge m -> result and result_valid valid in cycle m+1.
- Next grant no earlier than cycle m+2+HOLDOFF.
- Throughput for a continuous single requester: one conversion per (ADC latency + 3 + HOLDOFF) cycles.
- With all three requesting continuously, grants rotate 0,1,2,0...
- No requester waits more than two conversions.

## Configuration

- ADC_SCHED_TIMEOUT_EN defined:
  - WAIT counts cycles. On reaching TIMEOUT_CYCLES without adc_done, go to HOLDOFF with grant cleared and no result_valid.
  - timeout_err set, sticky until reset.
  - result is unchanged.
- ADC_SCHED_TIMEOUT_EN undefined:
  - No counter. WAIT persists until adc_done or reset.
  - timeout_err tied 0.

## Test plan

- Reset, then req=3'b001, mode_sel=3'b001; core returns 12'hABC after 20 cycles -> adc_start pulse one cycle with adc_channel=CH0; result=12'hABC; result_valid=3'b001 for one cycle; next grant after HOLDOFF cycles.
- req=3'b111, mode_sel=3'b111 held over 6 conversions -> grant order 001,010,100,001,010,100.
- req=3'b111, mode_sel=3'b010 -> only requester 1 granted; adc_channel=CH1 every conversion.
- mode_sel[2] cleared during WAIT of a requester-2 conversion -> result updated, result_valid stays 0, FSM returns to IDLE normally.
- Reset pulsed during WAIT, adc_done arriving 2 cycles later -> all outputs at reset values, no result_valid, next grant goes to requester 0.
- ADC_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, adc_done never sent -> after 16 WAIT cycles grant=0, timeout_err=1 and held, result unchanged, a later request is granted normally.
